// File: rtl/bf_pkg.sv
// Shared types and constants for the BF memory system.
package bf_pkg;

   typedef enum logic [1:0] {CLEAR, LOAD, TERM, RUN} bf_state_e;

   localparam int BF_ADDR_W = 16;
   localparam int BF_DATA_W = 8;
   localparam logic [BF_DATA_W-1:0] BF_TERM = 8'h00;

endpackage

// File: rtl/bf_spram.sv
// RAM with one write port and one registered read port.
// Reads return the old contents when reading and writing the same address.
module bf_spram #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] ram [2**AW];

   always_ff @(posedge clk)
      if (we) ram[waddr] <= wdata;

   // Only the output register is reset; the array contents are left as-is.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata <= '0;
      else        rdata <= ram[raddr];

endmodule

// File: rtl/bf_memsys.sv
// BF core memory responder: owns program and tape RAMs, clears the tape, loads the program.
// Optional BF_MEMSYS_BYPASS_EN: a tape write forwards its data to mem in the same cycle.
module bf_memsys
   import bf_pkg::*;
#(
   parameter int PRG_AW = 12,
   parameter int MEM_AW = 12
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [BF_ADDR_W-1:0] pc,
   input  logic [BF_ADDR_W-1:0] cursor,
   input  logic [BF_DATA_W-1:0] out,
   input  logic                 we,
   output logic [BF_DATA_W-1:0] prg,
   output logic [BF_DATA_W-1:0] mem,
   output logic                 cpu_hold,
   input  logic                 reload,
   input  logic                 ld_valid,
   input  logic [BF_DATA_W-1:0] ld_data,
   input  logic                 ld_last,
   output logic                 ld_ready
);

   bf_state_e           state, state_nx;
   logic [MEM_AW-1:0]   clr_addr;
   logic [PRG_AW-1:0]   ld_addr;
   logic                xfer, core_we;
   logic                prg_we, tape_we;
   logic [BF_DATA_W-1:0] prg_wdata, tape_wdata, tape_rd;
   logic [MEM_AW-1:0]   tape_waddr;
   logic                unused_hi;

   // Addresses wrap: upper core address bits are deliberately dropped.
   assign unused_hi = ^{pc[BF_ADDR_W-1:PRG_AW], cursor[BF_ADDR_W-1:MEM_AW]};

   assign xfer    = ld_valid & ld_ready;
   assign core_we = we & (state == RUN);

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= CLEAR;
      else          state <= state_nx;

   always_comb begin
      state_nx = state;
      cpu_hold = 1'b1;
      ld_ready = 1'b0;
      case (state)
         CLEAR: if (clr_addr == '1) state_nx = LOAD;
         LOAD: begin
            ld_ready = 1'b1;
            // A full RAM leaves no room for the terminator, so skip TERM.
            if (xfer) begin
               if (ld_addr == '1)  state_nx = RUN;
               else if (ld_last)   state_nx = TERM;
            end
         end
         TERM: state_nx = RUN;
         RUN: begin
            cpu_hold = 1'b0;
            if (reload) state_nx = CLEAR;
         end
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         clr_addr <= '0;
         ld_addr  <= '0;
      end else begin
         if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
         if (xfer)           ld_addr  <= ld_addr + 1'b1;
         if (state == RUN && reload) begin
            clr_addr <= '0;
            ld_addr  <= '0;
         end
      end

   assign prg_we     = xfer | (state == TERM);
   assign prg_wdata  = (state == TERM) ? BF_TERM : ld_data;
   assign tape_we    = (state == CLEAR) | core_we;
   assign tape_waddr = (state == CLEAR) ? clr_addr : cursor[MEM_AW-1:0];
   assign tape_wdata = (state == CLEAR) ? '0 : out;

   bf_spram #(.AW(PRG_AW), .DW(BF_DATA_W)) u_prg_ram (
      .clk(clock), .rst_n(reset_n),
      .we(prg_we), .waddr(ld_addr), .wdata(prg_wdata),
      .raddr(pc[PRG_AW-1:0]), .rdata(prg)
   );

   bf_spram #(.AW(MEM_AW), .DW(BF_DATA_W)) u_tape_ram (
      .clk(clock), .rst_n(reset_n),
      .we(tape_we), .waddr(tape_waddr), .wdata(tape_wdata),
      .raddr(cursor[MEM_AW-1:0]), .rdata(tape_rd)
   );

`ifdef BF_MEMSYS_BYPASS_EN
   logic                 byp_q;
   logic [BF_DATA_W-1:0] byp_d;

   // The write and read addresses are both cursor, so a core write always hits the read.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         byp_q <= 1'b0;
         byp_d <= '0;
      end else begin
         byp_q <= core_we;
         byp_d <= out;
      end

   assign mem = byp_q ? byp_d : tape_rd;
`else
   assign mem = tape_rd;
`endif

endmodule

// File: tb/tb_bf_memsys.sv
// Directed-vector bench for bf_memsys (default 12-bit program and tape address widths).
module tb_bf_memsys;
   import bf_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] pc, cursor;
   logic [7:0]  out, ld_data;
   logic        we, reload, ld_valid, ld_last;
   logic [7:0]  prg, mem;
   logic        cpu_hold, ld_ready;

   int n_chk  = 0;
   int n_pass = 0;

   bf_memsys #(.PRG_AW(12), .MEM_AW(12)) dut (
      .clock(clock), .reset_n(reset_n), .pc(pc), .cursor(cursor), .out(out), .we(we),
      .prg(prg), .mem(mem), .cpu_hold(cpu_hold), .reload(reload), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   // Outputs are sampled and inputs driven on the falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_clear(input string tag);
      int n = 0;
      while (!ld_ready && n < 10000) begin
         tick();
         n++;
      end
      chk(tag, 16'(n), 16'd4096);
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last);
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'hEE;
   endtask

   task automatic rd_prg(input string tag, input logic [15:0] a, input logic [7:0] exp);
      pc = a;
      tick();
      chk(tag, 16'(prg), 16'(exp));
   endtask

   task automatic rd_mem(input string tag, input logic [15:0] a, input logic [7:0] exp);
      cursor = a; we = 1'b0;
      tick();
      chk(tag, 16'(mem), 16'(exp));
   endtask

   task automatic wr_mem(input logic [15:0] a, input logic [7:0] d);
      cursor = a; out = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; pc = '0; cursor = '0; out = '0; we = 1'b0;
      reload = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      @(negedge clock); @(negedge clock);
      chk("rst_prg", 16'(prg), 16'h0);
      chk("rst_mem", 16'(mem), 16'h0);
      chk("rst_hold", 16'(cpu_hold), 16'h1);
      chk("rst_ldrdy", 16'(ld_ready), 16'h0);
      reset_n = 1'b1;
      wait_clear("clear_cycles");
      chk("hold_in_load", 16'(cpu_hold), 16'h1);

      // Core writes while held must be dropped.
      cursor = 16'd10; out = 8'h44; we = 1'b1;
      load_byte(8'h2B, 1'b0);
      load_byte(8'h5B, 1'b0);
      load_byte(8'h2D, 1'b0);
      we = 1'b0;
      load_byte(8'h5D, 1'b1);
      chk("term_hold", 16'(cpu_hold), 16'h1);
      tick();
      chk("run_hold", 16'(cpu_hold), 16'h0);
      chk("run_ldrdy", 16'(ld_ready), 16'h0);
      rd_prg("prg0", 16'd0, 8'h2B);
      rd_prg("prg1", 16'd1, 8'h5B);
      rd_prg("prg2", 16'd2, 8'h2D);
      rd_prg("prg3", 16'd3, 8'h5D);
      rd_prg("prg4_term", 16'd4, 8'h00);
      rd_prg("prg_wrap", 16'hF001, 8'h5B);

      wr_mem(16'd5, 8'h7F);
      rd_mem("mem5", 16'd5, 8'h7F);
      rd_mem("mem6_clr", 16'd6, 8'h00);
      rd_mem("mem10_held_we", 16'd10, 8'h00);
      wr_mem(16'd3, 8'h11);
`ifdef BF_MEMSYS_BYPASS_EN
      chk("rdw_bypass", 16'(mem), 16'h11);
`else
      chk("rdw_old", 16'(mem), 16'h00);
`endif
      rd_mem("mem3_after", 16'd3, 8'h11);
      wr_mem(16'h1005, 8'hA5);
      rd_mem("mem_wrap", 16'd5, 8'hA5);

      // Reload with a coincident write; sequence must restart.
      cursor = 16'd7; out = 8'h66; we = 1'b1; reload = 1'b1;
      tick();
      we = 1'b0; reload = 1'b0;
      chk("reload_hold", 16'(cpu_hold), 16'h1);
      chk("reload_ldrdy", 16'(ld_ready), 16'h0);
      wait_clear("clear_cycles2");

      // Fill the whole program RAM: last transfer goes straight to RUN.
      for (int i = 0; i < 4096; i++) begin
         ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A; ld_last = 1'b0;
         tick();
      end
      ld_valid = 1'b0;
      chk("full_run_hold", 16'(cpu_hold), 16'h0);
      chk("full_ldrdy", 16'(ld_ready), 16'h0);
      rd_prg("full_first", 16'd0, 8'h5A);
      rd_prg("full_last", 16'd4095, 8'hA5);
      rd_mem("mem5_reclr", 16'd5, 8'h00);

      // Reset in the middle of a load.
      reload = 1'b1;
      tick();
      reload = 1'b0;
      wait_clear("clear_cycles3");
      load_byte(8'h3E, 1'b0);
      load_byte(8'h3C, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_prg", 16'(prg), 16'h0);
      chk("mid_rst_mem", 16'(mem), 16'h0);
      chk("mid_rst_hold", 16'(cpu_hold), 16'h1);
      chk("mid_rst_ldrdy", 16'(ld_ready), 16'h0);
      @(negedge clock);
      reset_n = 1'b1;
      wait_clear("clear_cycles4");
      load_byte(8'h2E, 1'b1);
      tick();
      chk("rerun_hold", 16'(cpu_hold), 16'h0);
      rd_prg("reload_prg0", 16'd0, 8'h2E);
      rd_prg("reload_prg1_term", 16'd1, 8'h00);
      rd_prg("reload_prg2_stale", 16'd2, 8'h58);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
